// File: rtl/add_pkg.sv
// Shared types and helpers for the carry-pipelined adder.
package add_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ADC = 2'b10,
    MODE_SBB = 2'b11
  } mode_e;

  localparam int MAX_W = 64;

  function automatic int stages_of(
    input int width,
    input int seg
  );
    return width / seg;
  endfunction

  // Largest positive two's-complement value of the given width.
  function automatic logic [MAX_W-1:0] sat_max(
    input int width
  );
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(
    input int width
  );
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == width - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/add_pipe_seg_adder.sv
// Combinational SEG-bit ripple of full adders; exposes the
// carry into the top bit so the last segment can form ovf.
module seg_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         ci_msb
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co     = c[W];
  assign ci_msb = c[W-1];

endmodule

// File: rtl/add_pipe.sv
// Carry-pipelined add/sub, one SEG-bit segment per stage.
// Optional signed saturation: define ADD_PIPE_SAT_EN.
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = stages_of(WIDTH, SEG);

  logic                         en;
  logic [STAGES:0]              v;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES:0][WIDTH-1:0]   s_q;
  logic [STAGES:0]              c_q;
  logic                         cm_q;

  logic [STAGES-1:0][SEG-1:0]   seg_s;
  logic [STAGES-1:0]            seg_co;
  logic [STAGES-1:0]            seg_cm;

  logic [WIDTH-1:0]             b_in;
  logic                         c_in;
  logic [WIDTH-1:0]             ans_raw;

  assign en       = ~v[STAGES] | out_ready;
  assign in_ready = en;

  always_comb begin
    b_in = op2;
    c_in = 1'b0;
    unique case (mode_e'(mode))
      MODE_ADD: c_in = 1'b0;
      MODE_SUB: begin
        b_in = ~op2;
        c_in = 1'b1;
      end
      MODE_ADC: c_in = cin;
      MODE_SBB: begin
        b_in = ~op2;
        c_in = ~cin;
      end
      default: c_in = 1'b0;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    seg_adder #(.W(SEG)) u_seg (
      .a      (a_q[k][k*SEG +: SEG]),
      .b      (b_q[k][k*SEG +: SEG]),
      .ci     (c_q[k]),
      .s      (seg_s[k]),
      .co     (seg_co[k]),
      .ci_msb (seg_cm[k])
    );
  end

  // Rank 0 holds prepared operands; rank k+1 holds stage k results.
  always_ff @(posedge clk) begin
    if (rst) begin
      v           <= '0;
      s_q[STAGES] <= '0;
      c_q[STAGES] <= 1'b0;
      cm_q        <= 1'b0;
    end else if (en) begin
      v      <= {v[STAGES-1:0], in_valid};
      a_q[0] <= op1;
      b_q[0] <= b_in;
      c_q[0] <= c_in;
      s_q[0] <= '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k+1] <= a_q[k];
        b_q[k+1] <= b_q[k];
      end
      for (int k = 0; k < STAGES; k++) begin
        s_q[k+1]               <= s_q[k];
        s_q[k+1][k*SEG +: SEG] <= seg_s[k];
        c_q[k+1]               <= seg_co[k];
      end
      cm_q <= seg_cm[STAGES-1];
    end
  end

  assign out_valid = v[STAGES];
  assign ans_raw   = s_q[STAGES];
  assign cout      = c_q[STAGES];
  assign ovf       = cm_q ^ c_q[STAGES];

`ifdef ADD_PIPE_SAT_EN
  localparam logic [MAX_W-1:0] SMAX_F = sat_max(WIDTH);
  localparam logic [MAX_W-1:0] SMIN_F = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SMAX   = SMAX_F[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN   = SMIN_F[WIDTH-1:0];

  // A wrapped MSB of 1 means the true result overflowed positive.
  assign ans = ovf ? (ans_raw[WIDTH-1] ? SMAX : SMIN) : ans_raw;
`else
  assign ans = ans_raw;
`endif

  assign zero = v[STAGES] & ~|ans;

endmodule

// File: tb/tb_add_pipe.sv
// Randomised and directed bench for add_pipe (WIDTH=16, SEG=4).
// Results are scored against an arithmetic reference queue.
module tb_add_pipe;
  import add_pkg::*;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op1;
  logic [15:0] op2;
  logic        cin;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ans;
  logic        cout;
  logic        ovf;
  logic        zero;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  typedef struct packed {
    logic [15:0] ans;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t q[$];

  always #5 clk = ~clk;

  add_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .cin       (cin),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ans       (ans),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  function automatic res_t model(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        c,
    input logic [1:0]  m
  );
    res_t r;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int ci = 0;
    int u;
    int s;
    logic sub;
    sub = (m == 2'b01) || (m == 2'b11);
    if (m == 2'b10) ci = int'(c);
    if (m == 2'b11) ci = int'(c);
    if (sub) begin
      u = ua - ub - ci;
      s = sa - sb - ci;
      r.cout = (u >= 0);
    end else begin
      u = ua + ub + ci;
      s = sa + sb + ci;
      r.cout = (u > 65535);
    end
    r.ans = u[15:0];
    r.ovf = (s > 32767) || (s < -32768);
`ifdef ADD_PIPE_SAT_EN
    if (r.ovf) r.ans = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
    r.zero = (r.ans == 16'h0000);
    return r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, score any output handshake, advance.
  task automatic step(
    input  logic        iv,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c,
    input  logic [1:0]  m,
    input  logic        ordy,
    output logic        acc
  );
    res_t e;
    in_valid  = iv;
    op1       = a;
    op2       = b;
    cin       = c;
    mode      = m;
    out_ready = ordy;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, ~out_valid | ordy});
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("spurious", {31'b0, out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        pops++;
        chk("ans", {16'b0, ans}, {16'b0, e.ans});
        chk("cout", {31'b0, cout}, {31'b0, e.cout});
        chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
        chk("zero", {31'b0, zero}, {31'b0, e.zero});
      end
    end
    acc = iv && in_ready;
    if (acc) q.push_back(model(a, b, c, m));
    @(posedge clk);
    #1;
  endtask

  logic [15:0] da [10] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h1234,
                           16'h00FF, 16'h0100, 16'h8000, 16'h8000,
                           16'h7FFF, 16'hFFFF};
  logic [15:0] db [10] = '{16'h0001, 16'h0001, 16'h0001, 16'h1234,
                           16'h0000, 16'h0000, 16'h0001, 16'hFFFF,
                           16'hFFFF, 16'hFFFF};
  logic        dc [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                           1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0]  dm [10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10,
                           2'b11, 2'b01, 2'b00, 2'b01, 2'b11};

  initial begin
    logic acc;
    int   n;
    int   sent;
    int   p0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op1       = '0;
    op2       = '0;
    cin       = 1'b0;
    mode      = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ans", {16'b0, ans}, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    // Latency and the first carry-through case.
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 2'b00, 1'b1, acc);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, LAT);
    chk("lat_ans", {16'b0, ans}, 32'h0000);
    chk("lat_cout", {31'b0, cout}, 32'd1);
    chk("lat_zero", {31'b0, zero}, 32'd1);
    chk("lat_ovf", {31'b0, ovf}, 32'd0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b1, acc);

    // Directed boundary cases, back-to-back.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, da[i], db[i], dc[i], dm[i], 1'b1, acc);
    end
    repeat (LAT + 2) step(1'b0, 16'($urandom), 16'($urandom),
                          1'($urandom), 2'($urandom), 1'b1, acc);
    chk("dir_drain", q.size(), 0);

    // Eight beats with a five-cycle output stall mid-stream.
    p0   = pops;
    sent = 0;
    n    = 0;
    while (sent < 8 && n < 40) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom),
           2'($urandom), !(n >= 3 && n < 8), acc);
      if (acc) sent++;
      n++;
    end
    chk("stall_sent", sent, 8);
    repeat (LAT + 2) step(1'b0, 16'($urandom), 16'($urandom),
                          1'($urandom), 2'($urandom), 1'b1, acc);
    chk("stall_pops", pops - p0, 8);
    chk("stall_drain", q.size(), 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      step($urandom_range(0, 3) != 0, a, b, 1'($urandom),
           2'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    repeat (LAT + 4) step(1'b0, 16'($urandom), 16'($urandom),
                          1'($urandom), 2'($urandom), 1'b1, acc);
    chk("rand_drain", q.size(), 0);

    // Reset with beats in flight drops them.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom),
           2'($urandom), 1'b1, acc);
    end
    repeat (3) step(1'b0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b1, acc);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_ans", {16'b0, ans}, 32'd0);
    chk("mid_rst_cout", {31'b0, cout}, 32'd0);
    chk("mid_rst_ovf", {31'b0, ovf}, 32'd0);
    chk("mid_rst_zero", {31'b0, zero}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      chk("no_stale", {31'b0, out_valid}, 32'd0);
      step(1'b0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b1, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, carry-pipelined successor to the 8-bit ripple-carry adder.
- The WIDTH-bit add/subtract is split into SEG-bit ripple segments, one segment per pipeline stage; the carry is registered between stages.
- Valid/ready handshake on both sides; full throughput of one operation per cycle; supports backpressure.
- Sits in the ALU datapath as the arithmetic unit feeding the result mux and the flags register.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SEG.
- SEG, 4, bits per ripple segment. STAGES = WIDTH/SEG (derived localparam).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- op1  in  WIDTH  operand A.
- op2  in  WIDTH  operand B.
- cin  in  1  carry/borrow input (used by ADC/SBB only).
- mode  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- ans  out  WIDTH  sum/difference.
- cout  out  1  carry out; for SUB/SBB, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  ans == 0.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high: on a rising clk with rst=1, all stage valid bits clear. out_valid=0, ans=0, cout=0, ovf=0, zero=0. In-flight beats are dropped with no partial output. in_ready=1 in the cycle after reset.
- Operand prep at input:
  - B' = op2 for ADD/ADC; ~op2 for SUB/SBB.
  - c0 = 0 (ADD), 1 (SUB), cin (ADC), ~cin (SBB).
- Stage k (k = 0..STAGES-1):
  - Adds segment k of A and B' with the carry registered from stage k-1 (c0 for k=0).
  - Registers its SEG sum bits and its carry out.
  - Upper operand segments travel down the pipe unchanged (skew registers).
  - Lower sum segments are carried forward (deskew), so all bits emerge aligned.
- Latency: exactly STAGES cycles from the in_valid&&in_ready edge to out_valid=1, when the output is not stalled.
- Flags are computed at the final stage from the aligned result:
  - cout = final-stage carry.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|ans.
- Handshake:
  - Pipeline advance enable: en = ~out_valid | out_ready. in_ready = en (combinational).
  - en=0 freezes every stage (valids and data hold); output holds stable until accepted.
  - Bubbles (in_valid=0 when en=1) propagate as invalid stages; no bubble collapsing.
  - Simultaneous accept and output handshake in one cycle is legal: throughput 1/cycle.
- Boundaries:
  - A stall lasting any number of cycles changes no data.
  - Reset asserted during a stall clears everything in the following cycle.
  - mode and cin are sampled only at acceptance and carried in the pipe; changes after acceptance do not affect in-flight beats.

Optional Feature:
- Macro: ADD_PIPE_SAT_EN.
- Defined: signed saturation at the final stage. If ovf=1, ans = 0x7F..F when the true result is positive (MSB of ans=1), else 0x80..0. ovf still reports 1. zero reflects the saturated value. cout is unaffected.
- Undefined: ans is the raw wrap-around result. No extra logic.

Decomposition:
- Package add_pkg:
  - mode enum encodings (ADD, SUB, ADC, SBB).
  - Localparam helper for STAGES.
  - SAT_MAX/SAT_MIN constant functions of WIDTH.
- Sub-module seg_adder:
  - Parametrised SEG-bit combinational ripple of full adders.
  - Ports a, b, ci, s, co, plus ci_msb (carry into the top bit) for the ovf computation.
  - Instantiated STAGES times via generate.

Test Plan (WIDTH=16, SEG=4, latency 4):
- ADD 0xFFFF + 0x0001 -> after 4 cycles: ans=0x0000, cout=1, zero=1, ovf=0.
- ADD 0x7FFF + 0x0001 -> ans=0x8000, ovf=1, cout=0. With ADD_PIPE_SAT_EN: ans=0x7FFF, ovf=1.
- SUB 0x0000 - 0x0001 -> ans=0xFFFF, cout=0 (borrow), ovf=0. SUB 0x1234 - 0x1234 -> ans=0, zero=1, cout=1.
- ADC 0x00FF + 0x0000 with cin=1 -> 0x0100. SBB 0x0100 - 0x0000 with cin=1 -> 0x00FF, cout=1.
- Back-to-back: 8 beats streamed; hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, no beat lost or duplicated, results in order.
- Stream 3 beats, assert rst for 1 cycle while 2 are in flight -> next cycle out_valid=0 and all outputs 0; no stale beat ever appears.
